// File: rtl/bram_pkg.sv
// Shared constants and types for the 32x16K block RAM and its reader/writer stages.
package bram_pkg;

  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 32;
  localparam int RAM_DEPTH = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   len_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry first-word-fall-through FIFO; entry0 is always the head word.
module stream_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] entry0;
  logic [W-1:0] entry1;
  logic         pop_ok;

  assign pop_ok = pop && (count != 2'd0);
  assign head   = entry0;

  // Push-while-full only occurs together with a pop, so entry1 never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (count == 2'd0) entry0 <= push_data;
          else               entry1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            entry0 <= push_data;
          end else begin
            entry0 <= entry1;
            entry1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Read stage for the block RAM: issues a contiguous address range on one RAM port and
// streams the returned words out on a valid/ready interface with LAST marking.
module bram_stream_reader
  import bram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   issue_cnt;
  logic [ADDR_W:0]   beat_cnt;
  logic              in_flight;
  logic [1:0]        fifo_count;
  logic [2:0]        pending;
  logic              pop;
  logic              can_issue;
  logic              last_issue;

  assign ram_we     = 1'b0;
  assign busy       = (state != IDLE);
  assign m_valid    = (fifo_count != 2'd0);
  assign m_last     = m_valid && (beat_cnt == len_q - 1'b1);
  assign pop        = m_valid && m_ready;
  assign pending    = {1'b0, fifo_count} + {2'b00, in_flight};
  assign last_issue = (issue_cnt == len_q - 1'b1);
  // A beat leaving this cycle frees a slot, which keeps one word per cycle sustained.
  assign can_issue  = (state == RUN) && ((pending < 3'd2) || pop);

  stream_fifo2 #(.W(DATA_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_flight),
    .push_data (ram_rdata),
    .pop       (pop),
    .head      (m_data),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (length == '0) ? FIN : RUN;
      RUN:     if (can_issue && last_issue) state_nxt = DRAIN;
      DRAIN:   if (pop && m_last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ram_addr is the address the RAM samples at the next issuing edge; it stops on the final word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      issue_cnt <= '0;
      beat_cnt  <= '0;
      ram_addr  <= '0;
      in_flight <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= (state == FIN);
      in_flight <= can_issue;
      if (state == IDLE && start) begin
        len_q     <= length;
        issue_cnt <= '0;
        beat_cnt  <= '0;
        ram_addr  <= base_addr;
      end else begin
        if (can_issue) begin
          issue_cnt <= issue_cnt + 1'b1;
          if (!last_issue) ram_addr <= ram_addr + 1'b1;
        end
        if (pop) beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

endmodule
